collision_probe_scheduler: RTL and testbench
============================================

Name: collision_probe_scheduler

Overview:
- Once per frame, samples the character position and checks the four tiles around it: left, right, above and below.
- Reads those tiles from the single-port tile-map RAM, which is shared with the renderer through an external req/gnt arbiter.
- Registers the results as the four blocked flags and pulses move_enable, so the character-movement datapath advances exactly one step per frame using consistent collision data.

Parameters:
CHAR_W, 8, character width in pixels
CHAR_H, 16, character height in pixels
TILE_SHIFT, 3, log2 of tile size in pixels (8x8 tiles)
MAP_W, 20, map width in tiles
MAP_H, 15, map height in tiles
ADDR_W, 9, tile-map RAM address width
DATA_W, 4, tile-map RAM data width
RD_LAT, 1, tile-map RAM read latency in cycles (1..3)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse, start of a scan
char_x  in  8  character left edge, pixels
char_y  in  8  character top edge, pixels
mem_req  out  1  request for tile-map RAM
mem_gnt  in  1  grant from arbiter
mem_rd  out  1  one-cycle read strobe
mem_addr  out  ADDR_W  tile address = ty*MAP_W + tx
mem_rdata  in  DATA_W  tile code; nonzero = solid
left_blocked  out  1  registered collision flag
right_blocked  out  1  registered collision flag
up_blocked  out  1  registered collision flag
down_blocked  out  1  registered collision flag
move_enable  out  1  one-cycle pulse, flags valid
busy  out  1  scan in progress
overrun  out  1  one-cycle pulse, tick arrived while busy

Behaviour:
- Reset, synchronous, while resetn=0:
  - All four blocked flags = 1, which freezes the character until the first scan.
  - mem_req=0, mem_rd=0, mem_addr=0, move_enable=0, busy=0, overrun=0.
  - FSM goes to IDLE.
  - Reset asserted mid-scan aborts the scan and drops mem_req on the next edge. Partial results are discarded.
- FSM states: IDLE, LATCH, REQ, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: on frame_tick=1 go to LATCH.
- LATCH: register char_x/char_y and compute the 4 probe points in 10-bit signed arithmetic. Next state is REQ.
  - left: (x-1, y+CHAR_H/2)
  - right: (x+CHAR_W, y+CHAR_H/2)
  - up: (x+CHAR_W/2, y-1)
  - down: (x+CHAR_W/2, y+CHAR_H)
  - Tile coords: tx = px>>>TILE_SHIFT, ty = py>>>TILE_SHIFT.
  - A probe is out of bounds if tx<0, tx>=MAP_W, ty<0 or ty>=MAP_H.
- REQ: mem_req=1. Stay until mem_gnt=1 is sampled, then go to ISSUE with probe index 0.
  - mem_req stays high from REQ until DONE. The arbiter must not revoke the grant while mem_req=1.
- Probe order is left, right, up, down.
- ISSUE, in-bounds probe:
  - mem_rd=1 and mem_addr valid for exactly one cycle.
  - Spend RD_LAT-1 cycles in WAIT.
  - Sample mem_rdata in CAPTURE, exactly RD_LAT cycles after ISSUE. The result is solid = (mem_rdata != 0).
- ISSUE, out-of-bounds probe:
  - No mem_rd; the result is decided in the ISSUE cycle.
  - left, right and down are blocked (1). up is not blocked (0), so the head may leave the top of the screen.
- After the 4th probe go to DONE.
- DONE, one cycle:
  - All four flags update simultaneously from the scan results.
  - move_enable=1 and mem_req=0.
  - Next state is IDLE.
- Flags change only in DONE and hold their values between scans.
- busy=1 in every state except IDLE.
- frame_tick while busy=1: ignored, and overrun pulses for 1 cycle.
- frame_tick in the DONE cycle also counts as an overrun.
- Latency, with mem_gnt already high, RD_LAT=1 and all probes in bounds: move_enable is high 11 cycles after the edge that samples frame_tick (LATCH 1 + REQ 1 + 4x2 + DONE 1).
  - Each cycle that mem_gnt is held low in REQ adds 1 cycle.
  - Each out-of-bounds probe subtracts RD_LAT cycles.
- mem_addr arithmetic: ty*MAP_W + tx, computed unsigned in ADDR_W bits for in-bounds probes only. No wrap is possible for legal parameters.

Test Plan:
- Reset: resetn=0 for 2 cycles -> all flags=1, mem_req=0, busy=0, move_enable=0.
- Nominal scan: x=72, y=40, mem_gnt tied 1, RAM all zero, tick -> mem_rd addresses 128, 130, 89, 149 in that order; move_enable 11 cycles after tick; all flags=0.
- Solid tiles: same position, RAM[130]=3 and RAM[149]=1 -> right_blocked=1, down_blocked=1, left_blocked=0, up_blocked=0. Flags stay stable until the next DONE.
- Boundaries: x=72, y=0 -> up probe skipped (3 mem_rd pulses), up_blocked=0. Then y=104 -> down probe ty=15 skipped, down_blocked=1. Then x=0 -> left_blocked=1 with no read.
- Arbitration and overrun: mem_gnt low for 5 cycles after tick -> mem_req held, no mem_rd until grant, move_enable at 16 cycles. A second tick 3 cycles after the first -> one overrun pulse, and exactly one move_enable.
- Reset mid-scan: resetn=0 in WAIT of the up probe -> mem_req=0 next cycle, flags=1, no move_enable. A tick after release performs a full clean scan.

Source files
------------

// File: rtl/collision_probe_scheduler_if.sv
// Tile-map RAM port shared with the renderer through an external req/gnt arbiter.
//   req   : scheduler wants the RAM (held from request until scan end)
//   gnt   : arbiter grant; must not be revoked while req is high
//   rd    : one-cycle read strobe
//   addr  : tile address, ty*MAP_W + tx
//   rdata : tile code returned RD_LAT cycles after rd; nonzero = solid
interface collision_probe_scheduler_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 4
);
    logic              req;
    logic              gnt;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output rd, output addr, input gnt, input rdata);
    modport slave  (input req, input rd, input addr, output gnt, output rdata);
endinterface

// File: rtl/collision_probe_scheduler.sv
// Once per frame, probes the four tiles around the character (left, right, up,
// down) through the shared tile-map RAM and publishes registered blocked flags
// together with a one-cycle move_enable, so movement uses one consistent snapshot.
//   clock, resetn      : clock, synchronous active-low reset
//   frame_tick         : one-cycle scan start pulse
//   char_x, char_y     : character top-left corner in pixels
//   mem                : tile-map RAM master port (req/gnt/rd/addr/rdata)
//   *_blocked          : collision flags, updated together once per scan
//   move_enable        : one-cycle pulse, flags valid
//   busy               : scan in progress
//   overrun            : one-cycle pulse, tick arrived while busy
module collision_probe_scheduler #(
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int TILE_SHIFT = 3,
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        frame_tick,
    input  logic [7:0]                  char_x,
    input  logic [7:0]                  char_y,
    collision_probe_scheduler_if.master mem,
    output logic                        left_blocked,
    output logic                        right_blocked,
    output logic                        up_blocked,
    output logic                        down_blocked,
    output logic                        move_enable,
    output logic                        busy,
    output logic                        overrun
);
    typedef enum logic [2:0] {
        StIdle, StLatch, StReq, StIssue, StWait, StCapture, StDone
    } state_t;

    localparam logic signed [9:0] HALF_W = 10'(CHAR_W / 2);
    localparam logic signed [9:0] HALF_H = 10'(CHAR_H / 2);
    localparam logic signed [9:0] FULL_W = 10'(CHAR_W);
    localparam logic signed [9:0] FULL_H = 10'(CHAR_H);
    localparam logic signed [9:0] ONE    = 10'sd1;

    // Probe index order: 0 left, 1 right, 2 up, 3 down.
    localparam logic [1:0] IDX_UP   = 2'd2;
    localparam logic [1:0] IDX_LAST = 2'd3;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        wait_q, wait_d;
    logic [3:0]        res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic              overrun_q;
    // {out_of_bounds, address} per probe
    logic [ADDR_W:0]   probe_q [4];
    logic signed [9:0] x10, y10;

    assign x10 = signed'({2'b00, char_x});
    assign y10 = signed'({2'b00, char_y});

    function automatic logic [ADDR_W:0] probe(input logic signed [9:0] px,
                                              input logic signed [9:0] py);
        int tx;
        int ty;
        logic oob;
        tx  = int'(px >>> TILE_SHIFT);
        ty  = int'(py >>> TILE_SHIFT);
        oob = (tx < 0) || (tx >= MAP_W) || (ty < 0) || (ty >= MAP_H);
        // Address only matters for in-bounds probes; zero it otherwise.
        return {oob, oob ? {ADDR_W{1'b0}} : ADDR_W'(ty * MAP_W + tx)};
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        res_d       = res_q;
        flags_d     = flags_q;
        mem.req     = 1'b0;
        mem.rd      = 1'b0;
        mem.addr    = '0;
        move_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_tick) state_d = StLatch;
            end
            StLatch: begin
                state_d = StReq;
            end
            StReq: begin
                mem.req = 1'b1;
                if (mem.gnt) begin
                    idx_d   = 2'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem.req = 1'b1;
                if (probe_q[idx_q][ADDR_W]) begin
                    // Off-map: solid everywhere except above, so the head may leave the top.
                    res_d[idx_q] = (idx_q != IDX_UP);
                    if (idx_q == IDX_LAST) state_d = StDone;
                    else idx_d = idx_q + 2'd1;
                end else begin
                    mem.rd   = 1'b1;
                    mem.addr = probe_q[idx_q][ADDR_W-1:0];
                    if (RD_LAT > 1) begin
                        wait_d  = 2'(RD_LAT - 2);
                        state_d = StWait;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StWait: begin
                mem.req = 1'b1;
                if (wait_q == 2'd0) state_d = StCapture;
                else wait_d = wait_q - 2'd1;
            end
            StCapture: begin
                mem.req      = 1'b1;
                res_d[idx_q] = (mem.rdata != {DATA_W{1'b0}});
                if (idx_q == IDX_LAST) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                move_enable = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Load all flags on entry to DONE so they are valid alongside move_enable.
        if (state_d == StDone) flags_d = res_d;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            wait_q    <= 2'd0;
            res_q     <= 4'h0;
            flags_q   <= 4'hF;
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++) probe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            overrun_q <= frame_tick && (state_q != StIdle);
            if (state_q == StLatch) begin
                probe_q[0] <= probe(x10 - ONE,    y10 + HALF_H);
                probe_q[1] <= probe(x10 + FULL_W, y10 + HALF_H);
                probe_q[2] <= probe(x10 + HALF_W, y10 - ONE);
                probe_q[3] <= probe(x10 + HALF_W, y10 + FULL_H);
            end
        end
    end

    assign left_blocked  = flags_q[0];
    assign right_blocked = flags_q[1];
    assign up_blocked    = flags_q[2];
    assign down_blocked  = flags_q[3];
    assign busy          = (state_q != StIdle);
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_collision_probe_scheduler.sv
// Directed bench for collision_probe_scheduler with a 1-cycle-latency RAM model.
module tb_collision_probe_scheduler;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] char_x = 8'd0;
    logic [7:0] char_y = 8'd0;
    logic       left_blocked, right_blocked, up_blocked, down_blocked;
    logic       move_enable, busy, overrun;
    logic [3:0] flags;

    collision_probe_scheduler_if #(.ADDR_W(9), .DATA_W(4)) mem_bus ();

    collision_probe_scheduler dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .char_x        (char_x),
        .char_y        (char_y),
        .mem           (mem_bus),
        .left_blocked  (left_blocked),
        .right_blocked (right_blocked),
        .up_blocked    (up_blocked),
        .down_blocked  (down_blocked),
        .move_enable   (move_enable),
        .busy          (busy),
        .overrun       (overrun)
    );

    // Hex digit reads as {left, right, up, down}.
    assign flags = {left_blocked, right_blocked, up_blocked, down_blocked};

    always #5 clock = ~clock;

    logic [3:0] ram [512];
    int total = 0;
    int bad = 0;
    int moves = 0;
    int overruns = 0;
    int rd_q[$];
    int lat;

    always @(posedge clock) begin
        if (mem_bus.rd) mem_bus.rdata <= ram[mem_bus.addr];
    end

    always @(negedge clock) begin
        if (mem_bus.rd === 1'b1) rd_q.push_back(int'(mem_bus.addr));
        if (move_enable === 1'b1) moves++;
        if (overrun === 1'b1) overruns++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one scan. Cycle 1 is the cycle after the edge that samples the tick.
    // gnt_at: cycle at which grant is raised (0 = already high).
    // tick2_at: cycle in which a second tick is driven (0 = none).
    task automatic scan(input logic [7:0] x, input logic [7:0] y, input int gnt_at,
                        input int tick2_at, output int latency);
        char_x = x;
        char_y = y;
        rd_q.delete();
        moves = 0;
        overruns = 0;
        frame_tick = 1'b1;
        step();
        latency = 0;
        for (int n = 1; n <= 60; n++) begin
            frame_tick = (n == tick2_at);
            if (n == gnt_at) mem_bus.gnt = 1'b1;
            if (gnt_at > 0 && n == gnt_at - 1) begin
                check_eq("req_held_no_gnt", 32'(mem_bus.req), 1);
                check_eq("no_rd_before_gnt", rd_q.size(), 0);
            end
            if (move_enable) begin
                latency = n;
                break;
            end
            step();
        end
        frame_tick = 1'b0;
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 4'd0;
        mem_bus.gnt = 1'b1;

        // Reset
        resetn = 1'b0;
        step();
        step();
        check_eq("rst_flags", 32'(flags), 32'hF);
        check_eq("rst_req", 32'(mem_bus.req), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_move", 32'(move_enable), 0);
        resetn = 1'b1;
        step();

        // Nominal scan, empty map
        scan(8'd72, 8'd40, 0, 0, lat);
        check_eq("nom_latency", lat, 11);
        check_eq("nom_nreads", rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            check_eq("nom_addr_left", rd_q[0], 128);
            check_eq("nom_addr_right", rd_q[1], 130);
            check_eq("nom_addr_up", rd_q[2], 89);
            check_eq("nom_addr_down", rd_q[3], 149);
        end
        check_eq("nom_flags", 32'(flags), 32'h0);
        check_eq("nom_moves", moves, 1);
        check_eq("nom_idle", 32'(busy), 0);

        // Solid tiles right and below
        ram[130] = 4'd3;
        ram[149] = 4'd1;
        scan(8'd72, 8'd40, 0, 0, lat);
        check_eq("solid_flags", 32'(flags), 32'b0101);
        for (int i = 0; i < 5; i++) step();
        check_eq("solid_flags_hold", 32'(flags), 32'b0101);

        // Top edge: up probe off-map, not blocked
        scan(8'd72, 8'd0, 0, 0, lat);
        check_eq("top_latency", lat, 10);
        check_eq("top_nreads", rd_q.size(), 3);
        if (rd_q.size() == 3) check_eq("top_addr_down", rd_q[2], 49);
        check_eq("top_flags", 32'(flags), 32'b0000);

        // Bottom edge: down probe at ty=15 off-map, blocked
        scan(8'd72, 8'd104, 0, 0, lat);
        check_eq("bot_nreads", rd_q.size(), 3);
        if (rd_q.size() == 3) check_eq("bot_addr_up", rd_q[2], 249);
        check_eq("bot_flags", 32'(flags), 32'b0001);

        // Left edge: left probe off-map, blocked, no read
        scan(8'd0, 8'd40, 0, 0, lat);
        check_eq("left_nreads", rd_q.size(), 3);
        if (rd_q.size() == 3) check_eq("left_addr_right", rd_q[0], 121);
        check_eq("left_flags", 32'(flags), 32'b1000);
        check_eq("left_latency", lat, 10);

        // Grant withheld for 5 REQ cycles, second tick mid-scan
        mem_bus.gnt = 1'b0;
        scan(8'd72, 8'd40, 7, 3, lat);
        check_eq("arb_latency", lat, 16);
        check_eq("arb_overruns", overruns, 1);
        check_eq("arb_moves", moves, 1);
        check_eq("arb_flags", 32'(flags), 32'b0101);

        // Reset while waiting on the up probe's data
        mem_bus.gnt = 1'b1;
        char_x = 8'd72;
        char_y = 8'd40;
        moves = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int n = 1; n < 8; n++) step();
        check_eq("mid_busy_before", 32'(busy), 1);
        resetn = 1'b0;
        step();
        check_eq("mid_req_dropped", 32'(mem_bus.req), 0);
        check_eq("mid_flags", 32'(flags), 32'hF);
        check_eq("mid_busy", 32'(busy), 0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("mid_no_move", moves, 0);
        scan(8'd72, 8'd40, 0, 0, lat);
        check_eq("post_latency", lat, 11);
        check_eq("post_nreads", rd_q.size(), 4);
        check_eq("post_flags", 32'(flags), 32'b0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
